// File: rtl/uart_packet_sender.sv
// uart_packet_sender
// Sends a framed packet over an 8N1 UART line: HEADER, payload bytes taken
// from a 256x8 buffer, then TRAILER. A payload byte of 8'hFF goes out as 8'hFE
// so that it cannot be mistaken for the trailer. The substitution is recorded
// in the internal sticky flag ff_sub_q.
// Optional feature: define UART_PACKET_SENDER_ACK_WAIT_EN to build an 8N1
// receiver on rx. After the trailer the block then waits for one
// acknowledge byte from the peer, or for a timeout.
module uart_packet_sender #(
  parameter int          CLK_FREQ    = 50_000_000,
  parameter int          BAUD_RATE   = 115200,
  parameter logic [7:0]  HEADER      = 8'hFE,
  parameter logic [7:0]  TRAILER     = 8'hFF,
  parameter logic [7:0]  ACK_BYTE    = 8'hAA,
  parameter int          ACK_TIMEOUT = 50_000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] pkt_len,
  input  logic       start,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       ack_err
);

  localparam int         BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam logic [8:0] BIT_LAST   = 9'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HDR  = 3'd1,
    SEND_DATA = 3'd2,
    SEND_TRL  = 3'd3,
    WAIT_ACK  = 3'd4,
    FINISH    = 3'd5
  } state_t;

  // A payload 8'hFF would look like the trailer, so it is sent as 8'hFE.
  function automatic logic [7:0] sub_ff(input logic [7:0] b);
    return (b == 8'hFF) ? 8'hFE : b;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic        load_pend_q, load_pend_d;
  logic        ff_sub_q, ff_sub_d;
  logic        ack_ok_q, ack_ok_d;
  logic        ack_err_q, ack_err_d;
  logic        busy_q, done_q;

  // Serializer state: sh_q[0] is the bit currently on the line (one cycle before tx_q).
  logic [9:0]  sh_q;
  logic [8:0]  baud_q;
  logic [3:0]  bit_q;
  logic        active_q;
  logic        tx_q;

  logic        load_s;
  logic [7:0]  load_byte_s;
  logic        byte_end_s;
  logic [7:0]  first_raw_s;
  logic [7:0]  next_raw_s;
  logic        unused_ok_s;

  logic [7:0]  mem_q [256];

`ifdef UART_PACKET_SENDER_ACK_WAIT_EN
  localparam logic [8:0]  HALF_LAST = 9'(BIT_PERIOD / 2 - 1);
  localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  logic [8:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_s1_q, rx_s2_q;
  logic [15:0] ack_cnt_q, ack_cnt_d;
`endif

  assign first_raw_s = mem_q[8'd0];
  assign next_raw_s  = mem_q[idx_q + 8'd1];
  assign byte_end_s  = active_q && (baud_q == BIT_LAST) && (bit_q == 4'd9);

  // Payload buffer: writable only while no frame is in progress, never reset.
  always_ff @(posedge clk_50m) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Frame sequencer: next state, byte selection and sticky flags.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    load_pend_d = 1'b0;
    load_s      = 1'b0;
    load_byte_s = HEADER;
    ff_sub_d    = ff_sub_q;
    ack_ok_d    = ack_ok_q;
    ack_err_d   = ack_err_q;
`ifdef UART_PACKET_SENDER_ACK_WAIT_EN
    ack_cnt_d   = 16'd0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SEND_HDR;
          len_d       = pkt_len;
          idx_d       = 8'd0;
          load_pend_d = 1'b1;
          ff_sub_d    = 1'b0;
          ack_ok_d    = 1'b0;
          ack_err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_HDR: begin
        if (load_pend_q) begin
          load_s      = 1'b1;
          load_byte_s = HEADER;
        end else if (byte_end_s) begin
          load_s = 1'b1;
          if (len_q == 8'd0) begin
            state_d     = SEND_TRL;
            load_byte_s = TRAILER;
          end else begin
            state_d     = SEND_DATA;
            idx_d       = 8'd0;
            load_byte_s = sub_ff(first_raw_s);
            ff_sub_d    = ff_sub_q | (first_raw_s == 8'hFF);
          end
        end else begin
          state_d = SEND_HDR;
        end
      end
      SEND_DATA: begin
        if (byte_end_s) begin
          load_s = 1'b1;
          if (idx_q == (len_q - 8'd1)) begin
            state_d     = SEND_TRL;
            load_byte_s = TRAILER;
          end else begin
            idx_d       = idx_q + 8'd1;
            load_byte_s = sub_ff(next_raw_s);
            ff_sub_d    = ff_sub_q | (next_raw_s == 8'hFF);
          end
        end else begin
          state_d = SEND_DATA;
        end
      end
      SEND_TRL: begin
        if (byte_end_s) begin
`ifdef UART_PACKET_SENDER_ACK_WAIT_EN
          state_d = WAIT_ACK;
`else
          state_d = FINISH;
`endif
        end else begin
          state_d = SEND_TRL;
        end
      end
      WAIT_ACK: begin
`ifdef UART_PACKET_SENDER_ACK_WAIT_EN
        if (rx_valid_q) begin
          state_d = FINISH;
          if (rx_sh_q == ACK_BYTE) begin
            ack_ok_d = 1'b1;
          end else begin
            ack_err_d = 1'b1;
          end
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d   = FINISH;
          ack_err_d = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + 16'd1;
        end
`else
        state_d = FINISH;
`endif
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers and registered status outputs.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 8'd0;
      len_q       <= 8'd0;
      load_pend_q <= 1'b0;
      ff_sub_q    <= 1'b0;
      ack_ok_q    <= 1'b0;
      ack_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      load_pend_q <= load_pend_d;
      ff_sub_q    <= ff_sub_d;
      ack_ok_q    <= ack_ok_d;
      ack_err_q   <= ack_err_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_q == FINISH);
    end
  end

  // Bit serializer: loads a full 10-bit symbol and shifts it out every BIT_PERIOD clocks.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sh_q     <= 10'h3FF;
      baud_q   <= 9'd0;
      bit_q    <= 4'd0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= sh_q[0];
      if (load_s) begin
        sh_q     <= {1'b1, load_byte_s, 1'b0};
        baud_q   <= 9'd0;
        bit_q    <= 4'd0;
        active_q <= 1'b1;
      end else if (byte_end_s) begin
        sh_q     <= 10'h3FF;
        baud_q   <= 9'd0;
        bit_q    <= 4'd0;
        active_q <= 1'b0;
      end else if (active_q) begin
        if (baud_q == BIT_LAST) begin
          baud_q <= 9'd0;
          bit_q  <= bit_q + 4'd1;
          sh_q   <= {1'b1, sh_q[9:1]};
        end else begin
          baud_q <= baud_q + 9'd1;
        end
      end
    end
  end

`ifdef UART_PACKET_SENDER_ACK_WAIT_EN
  // Two-flop synchronizer for the asynchronous rx line.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Receiver: confirm start at mid-bit, sample data mid-bit, require a high stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = 9'd0;
        end else begin
          rx_state_d = R_IDLE;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = 9'd0;
          rx_bit_d = 3'd0;
          if (!rx_s2_q) begin
            rx_state_d = R_DATA;
          end else begin
            rx_state_d = R_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 9'd1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = 9'd0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 9'd1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = 9'd0;
          rx_state_d = R_IDLE;
          rx_valid_d = rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 9'd1;
        end
      end
      default: begin
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // Receiver and acknowledge-timeout registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= 9'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      rx_valid_q <= 1'b0;
      ack_cnt_q  <= 16'd0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  assign unused_ok_s = ff_sub_q;
`else
  assign unused_ok_s = ^{rx, ff_sub_q, ACK_BYTE, 16'(ACK_TIMEOUT)};
`endif

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_ok  = ack_ok_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_uart_packet_sender.sv
// Testbench for uart_packet_sender. A frame model (expected byte list plus
// line timing arithmetic) predicts tx, busy and done on every cycle, and
// directed checks pin latencies and decoded bytes to literal values.
module tb_uart_packet_sender;

  localparam int BP        = 434;
  localparam int BYTE_CLKS = 4340;
`ifdef UART_PACKET_SENDER_ACK_WAIT_EN
  localparam bit ACKB = 1'b1;
`else
  localparam bit ACKB = 1'b0;
`endif

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_addr = 8'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] pkt_len = 8'd0;
  logic       start   = 1'b0;
  logic       rx      = 1'b1;
  logic       tx, busy, done, ack_ok, ack_err;

  uart_packet_sender dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pkt_len(pkt_len), .start(start), .rx(rx),
    .tx(tx), .busy(busy), .done(done), .ack_ok(ack_ok), .ack_err(ack_err)
  );

  always #10 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl_mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] cap_q [$];
  logic [7:0] cap_b;
  int         acc    = 0;
  bit         mdl_on = 1'b0;

  int         m, n, t, bi, bt;
  logic [7:0] eb;
  logic       etx, ebusy, edone;
  int         lat;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Per-cycle comparison against the frame model.
  always @(negedge clk_50m) begin
    etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
    m = 0; n = 0;
    if (mdl_on && rst_n) begin
      m = cyc - acc;
      n = exp_q.size();
      t = m - 2;
      if (t >= 0 && t < n * BYTE_CLKS) begin
        bi = t / BYTE_CLKS;
        bt = (t % BYTE_CLKS) / BP;
        eb = exp_q[bi];
        if (bt == 0) etx = 1'b0;
        else if (bt == 9) etx = 1'b1;
        else etx = eb[bt-1];
        if ((t % BP) == BP / 2 && bt >= 1 && bt <= 8) begin
          cap_b[bt-1] = tx;
          if (bt == 8) cap_q.push_back(cap_b);
        end
      end
      ebusy = (m >= 0) && (m < n * BYTE_CLKS + 2);
      edone = (m == n * BYTE_CLKS + 2);
    end
    chk("tx_line", int'(tx), int'(etx));
    if (!(ACKB && mdl_on && rst_n && m >= n * BYTE_CLKS + 2)) begin
      chk("busy_flag", int'(busy), int'(ebusy));
      chk("done_pulse", int'(done), int'(edone));
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_50m);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    mdl_mem[a] = d;
    @(negedge clk_50m);
    wr_en = 1'b0;
  endtask

  task automatic send(input int len);
    exp_q.delete();
    exp_q.push_back(8'hFE);
    for (int i = 0; i < len; i++)
      exp_q.push_back((mdl_mem[i] == 8'hFF) ? 8'hFE : mdl_mem[i]);
    exp_q.push_back(8'hFF);
    @(negedge clk_50m);
    cap_q.delete();
    pkt_len = 8'(len);
    start   = 1'b1;
    acc     = cyc + 1;
    mdl_on  = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
  endtask

  task automatic wait_done(output int l, input int budget);
    bit seen;
    seen = 1'b0;
    l = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_50m);
      if (done) begin
        seen = 1'b1;
        l = cyc - acc;
        chk("busy_low_at_done", int'(busy), 0);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk_50m);
    mdl_on = 1'b0;
  endtask

  task automatic wait_m(input int target);
    while ((cyc - acc) < target) @(negedge clk_50m);
  endtask

`ifdef UART_PACKET_SENDER_ACK_WAIT_EN
  task automatic peer(input logic [7:0] b);
    rx = 1'b0;
    repeat (BP) @(negedge clk_50m);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BP) @(negedge clk_50m);
    end
    rx = 1'b1;
    repeat (BP) @(negedge clk_50m);
  endtask
`endif

  initial begin
    // Reset state.
    repeat (3) @(negedge clk_50m);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack_ok", int'(ack_ok), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50m);

`ifdef UART_PACKET_SENDER_ACK_WAIT_EN
    // Peer acknowledges correctly.
    send(0);
    wait_m(2 * BYTE_CLKS + 2);
    peer(8'hAA);
    wait_done(lat, 20000);
    chk("ack_good_ok", int'(ack_ok), 1);
    chk("ack_good_err", int'(ack_err), 0);
    // Peer returns a wrong byte.
    send(0);
    chk("ack_cleared_on_start", int'(ack_ok), 0);
    wait_m(2 * BYTE_CLKS + 2);
    peer(8'h5A);
    wait_done(lat, 20000);
    chk("ack_bad_ok", int'(ack_ok), 0);
    chk("ack_bad_err", int'(ack_err), 1);
    // Silence: timeout 50000 clocks after entering the wait.
    send(0);
    wait_done(lat, 70000);
    chk("ack_timeout_latency", lat, 58682);
    chk("ack_timeout_ok", int'(ack_ok), 0);
    chk("ack_timeout_err", int'(ack_err), 1);
`else
    // Basic three-byte frame.
    wr(8'd0, 8'h11); wr(8'd1, 8'h22); wr(8'd2, 8'h33);
    send(3);
    wait_done(lat, 25000);
    chk("t1_done_latency", lat, 21702);
    chk("t1_nbytes", cap_q.size(), 5);
    if (cap_q.size() == 5) begin
      chk("t1_b0", int'(cap_q[0]), 8'hFE);
      chk("t1_b1", int'(cap_q[1]), 8'h11);
      chk("t1_b2", int'(cap_q[2]), 8'h22);
      chk("t1_b3", int'(cap_q[3]), 8'h33);
      chk("t1_b4", int'(cap_q[4]), 8'hFF);
    end
    chk("t1_ff_sub", int'(dut.ff_sub_q), 0);
    chk("t1_ack_ok", int'(ack_ok), 0);
    chk("t1_ack_err", int'(ack_err), 0);

    // Empty payload.
    send(0);
    wait_done(lat, 12000);
    chk("t2_done_latency", lat, 8682);
    chk("t2_nbytes", cap_q.size(), 2);
    if (cap_q.size() == 2) chk("t2_b1", int'(cap_q[1]), 8'hFF);

    // FF substitution, with a start and a buffer write issued mid-frame.
    wr(8'd1, 8'hFF);
    send(2);
    wait_m(6000);
    @(negedge clk_50m);
    start = 1'b1; pkt_len = 8'd9; wr_en = 1'b1; wr_addr = 8'd0; wr_data = 8'h55;
    @(negedge clk_50m);
    start = 1'b0; wr_en = 1'b0;
    wait_done(lat, 20000);
    chk("t3_done_latency", lat, 17362);
    chk("t3_nbytes", cap_q.size(), 4);
    if (cap_q.size() == 4) chk("t3_sub_byte", int'(cap_q[2]), 8'hFE);
    chk("t3_ff_sub", int'(dut.ff_sub_q), 1);

    // Buffer kept its old value; ff_sub cleared by the new start.
    send(1);
    wait_done(lat, 15000);
    chk("t4_done_latency", lat, 13022);
    if (cap_q.size() == 3) chk("t4_buf0_kept", int'(cap_q[1]), 8'h11);
    else chk("t4_nbytes", cap_q.size(), 3);
    chk("t4_ff_sub_clear", int'(dut.ff_sub_q), 0);

    // Reset during payload byte 2, then a fresh frame.
    send(3);
    wait_m(2 + 2 * BYTE_CLKS + 500);
    #3;
    rst_n  = 1'b0;
    mdl_on = 1'b0;
    #1;
    chk("t5_rst_tx", int'(tx), 1);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done", int'(done), 0);
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (300) @(negedge clk_50m);
    send(1);
    wait_done(lat, 15000);
    chk("t5_new_frame_latency", lat, 13022);
    chk("t5_nbytes", cap_q.size(), 3);
`endif

    repeat (5) @(negedge clk_50m);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_packet_sender.md
UART_PACKET_SENDER -- requirements
Module: uart_packet_sender

Interface
REQ-001 Parameters SHALL be: CLK_FREQ 50_000_000 (clock Hz); BAUD_RATE 115200 (line rate); BIT_PERIOD CLK_FREQ/BAUD_RATE = 434 (clocks per bit); HEADER 8'hFE (frame start); TRAILER 8'hFF (frame end); ACK_BYTE 8'hAA (peer acknowledge); ACK_TIMEOUT 50_000 (clocks allowed for ACK).
REQ-002 clk_50m  input  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wr_en  input  1  payload buffer write strobe.
REQ-005 wr_addr  input  8  payload buffer write address.
REQ-006 wr_data  input  8  payload buffer write data.
REQ-007 pkt_len  input  8  payload byte count (0..255), sampled at start.
REQ-008 start  input  1  single-cycle frame send request.
REQ-009 rx  input  1  serial receive line, used only for the ACK.
REQ-010 tx  output  1  serial transmit line; 8N1, LSB first, idle high.
REQ-011 busy  output  1  high from accepted start until done.
REQ-012 done  output  1  one-cycle pulse at frame completion.
REQ-013 ack_ok  output  1  sticky: the peer returned ACK_BYTE.
REQ-014 ack_err  output  1  sticky: wrong ACK byte or ACK timeout.

Function
REQ-015 Buffer: 256x8 RAM; a write occurs when wr_en=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-016 start SHALL be accepted only in IDLE; start while busy=1 SHALL be ignored.
REQ-017 On accept: latch pkt_len; busy=1; clear ack_ok, ack_err and ff_sub on the next cycle.
REQ-018 tx SHALL go low (start bit) exactly 2 clocks after the accepting edge.
REQ-019 Each bit SHALL last exactly BIT_PERIOD clocks; each byte SHALL occupy 10*BIT_PERIOD = 4340 clocks; bytes SHALL be sent back-to-back with no idle gap.
REQ-020 Frame order SHALL be HEADER, then buf[0]..buf[len-1], then TRAILER.
REQ-021 pkt_len=0 SHALL send HEADER then TRAILER only.
REQ-022 A payload byte equal to 8'hFF SHALL be sent as 8'hFE and SHALL set the internal sticky flag ff_sub, which is visible only to verification.
REQ-023 FSM states SHALL be IDLE, SEND_HDR, SEND_DATA, SEND_TRL, WAIT_ACK, FINISH.
- IDLE->SEND_HDR on start.
- SEND_HDR->SEND_DATA after the HEADER stop bit if len>0, else ->SEND_TRL.
- SEND_DATA->SEND_TRL after the stop bit of byte len-1.
- SEND_TRL->WAIT_ACK (macro defined) or ->FINISH after the TRAILER stop bit.
- FINISH->IDLE after 1 clock.
REQ-024 In FINISH: done=1 for that cycle only; busy falls in the same cycle.
REQ-025 The byte index SHALL be 8 bits and SHALL never wrap, because len<=255.

Reset
REQ-026 Reset SHALL act immediately when asserted: tx=1, busy=0, done=0, ack_ok=0, ack_err=0, FSM=IDLE, all counters 0.
REQ-027 Reset during a frame SHALL abort the frame with tx high and no done pulse.
REQ-028 Buffer contents SHALL NOT be reset.

Configuration
REQ-029 Macro UART_PACKET_SENDER_ACK_WAIT_EN SHALL control the ACK wait:
- Defined: include a 2-flop rx synchronizer and an 8N1 receiver with mid-bit sampling and false-start rejection.
- Defined, WAIT_ACK behaviour: the first complete byte ends the wait. ACK_BYTE sets ack_ok=1; any other byte sets ack_err=1. No byte within ACK_TIMEOUT clocks of entering WAIT_ACK sets ack_err=1. Then go to FINISH.
- Defined, other states: bytes received outside WAIT_ACK SHALL be discarded.
- Undefined: no receiver logic is built; rx is unused; ack_ok=0 and ack_err=0 always; SEND_TRL goes directly to FINISH.

Verification
REQ-030 buf[0..2]=11,22,33; len=3; start -> tx carries FE 11 22 33 FF. Each bit is 434 clocks. busy=1 throughout. done pulses once, 5*4340+2 clocks after start.
REQ-031 len=0; start -> tx carries FE FF only, then done.
REQ-032 buf[1]=FF; len=2 -> second payload byte on the line is FE; ff_sub=1.
REQ-033 Mid-frame: issue start and write buf[0]=55 -> both ignored; the frame is unchanged; after done, buf[0] keeps its old value.
REQ-034 Macro defined: after TRAILER, peer sends AA -> ack_ok=1. Peer sends 5A -> ack_err=1. Silence for 50_000 clocks -> ack_err=1. Each case ends with done.
REQ-035 rst_n low during payload byte 2 -> tx=1 immediately, busy=0, no done; a new start after release sends a full frame.
